// File: rtl/axis_out_pack.sv
// axis_out_pack: buffers wide input beats (COLS columns of ROWS words) and
// emits the selected columns one per cycle, highest column index first.
`ifndef ROWS
`define ROWS 4
`endif
`ifndef COLS
`define COLS 8
`endif
`ifndef Y_BITS
`define Y_BITS 8
`endif
`ifndef Y_OUT_BITS
`define Y_OUT_BITS 8
`endif
`ifndef KW_MAX
`define KW_MAX 3
`endif
`ifndef W_BPT
`define W_BPT 16
`endif

module axis_out_pack #(
    parameter int unsigned ROWS       = `ROWS,
    parameter int unsigned COLS       = `COLS,
    parameter int unsigned WORD_WIDTH = `Y_BITS,
    parameter int unsigned Y_OUT_BITS = `Y_OUT_BITS,
    parameter int unsigned KW_MAX     = `KW_MAX,
    parameter int unsigned W_BPT      = `W_BPT,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                                aclk,
    input  logic                                areset,
    input  logic                                s_valid,
    input  logic                                s_last,
    output logic                                s_ready,
    input  logic [$clog2(KW_MAX/2+1)-1:0]       s_kw2,
    input  logic                                s_is_w_last,
    input  logic                                s_is_config,
    input  logic                                s_is_w_first_kw2,
    input  logic [COLS*ROWS*WORD_WIDTH-1:0]     s_data,
    input  logic                                m_ready,
    output logic                                m_valid,
    output logic                                m_last,
    output logic                                m_last_pkt,
    output logic [ROWS*WORD_WIDTH-1:0]          m_data,
    output logic [W_BPT-1:0]                    m_bytes_per_transfer
);

    localparam int unsigned COL_BITS  = ROWS * WORD_WIDTH;
    localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1);
    localparam int unsigned COL_IDX_W = (COLS > 1) ? $clog2(COLS) : 1;

    // Entry storage; columns remaining to emit are tracked in r_mask
    logic [COLS-1:0][COL_BITS-1:0] r_data [DEPTH];
    logic [COLS-1:0]               r_mask [DEPTH];
    logic [COLS-1:0]               r_last [DEPTH];
    logic [COLS-1:0]               r_lpkt [DEPTH];
    logic [W_BPT-1:0]              r_bpt  [DEPTH];
    logic [PTR_W-1:0]              r_wr_ptr;
    logic [PTR_W-1:0]              r_rd_ptr;
    logic [CNT_W-1:0]              r_count;

    int unsigned                   w_k;
    int unsigned                   w_kw2;
    logic [COLS-1:0]               w_valid;
    logic [COLS-1:0]               w_last;
    logic [COLS-1:0]               w_lpkt;
    logic [W_BPT-1:0]              w_bpt;
    logic                          w_push;
    logic                          w_pop;
    logic                          w_free;
    logic [COLS-1:0]               w_head_mask;
    logic [COLS-1:0]               w_col_oh;
    logic [COLS-1:0]               w_next_mask;
    logic [COL_IDX_W-1:0]          w_col;

    // Per-beat column masks and byte count derived from the kernel width
    always_comb begin
        w_kw2   = 32'(s_kw2);
        w_k     = 2 * w_kw2 + 1;
        w_valid = '0;
        w_last  = '0;
        w_lpkt  = '0;
        for (int unsigned i = 0; i < COLS; i++) begin
            if (s_is_w_last) begin
                w_valid[i] = ((((i + 1) % w_k) > w_kw2) || (((i + 1) % w_k) == 0))
                             && ((i + 1) <= (COLS / w_k) * w_k);
                w_last[i]  = ((i + 1) == w_kw2 + 1);
            end else begin
                w_valid[i] = (((i + 1) % w_k) == 0);
                w_last[i]  = ((i + 1) == w_k);
            end
            w_lpkt[i] = s_last && ((i + 1) == w_kw2 + 1);
        end
        w_bpt = W_BPT'((ROWS * (COLS / w_k) * (s_is_w_last ? w_kw2 + 1 : 1) * Y_OUT_BITS) / 8);
    end

    // Head column select: highest remaining mask bit
    always_comb begin
        w_head_mask = r_mask[r_rd_ptr];
        w_col       = '0;
        w_col_oh    = '0;
        for (int unsigned i = 0; i < COLS; i++) begin
            if (w_head_mask[i]) begin
                w_col       = COL_IDX_W'(i);
                w_col_oh    = '0;
                w_col_oh[i] = 1'b1;
            end
        end
        w_next_mask = w_head_mask & ~w_col_oh;
    end

    assign s_ready = (r_count < CNT_W'(DEPTH));
    assign m_valid = (r_count != '0);
    assign w_push  = s_valid && s_ready && !s_is_config && !s_is_w_first_kw2 && (|w_valid);
    assign w_pop   = m_valid && m_ready;
    assign w_free  = w_pop && (w_next_mask == '0);

    assign m_data               = m_valid ? r_data[r_rd_ptr][w_col] : '0;
    assign m_last               = m_valid && r_last[r_rd_ptr][w_col];
    assign m_last_pkt           = m_valid && r_lpkt[r_rd_ptr][w_col];
    assign m_bytes_per_transfer = m_valid ? r_bpt[r_rd_ptr] : '0;

    // Pointers, occupancy and remaining-column masks; push overrides a freed head slot
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mask[i] <= '0;
            end
        end else begin
            if (w_pop) begin
                r_mask[r_rd_ptr] <= w_next_mask;
            end
            if (w_free) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_mask[r_wr_ptr] <= w_valid;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_push && !w_free) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_free) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Payload storage needs no reset: outputs are gated by m_valid
    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_data[r_wr_ptr] <= s_data;
            r_last[r_wr_ptr] <= w_last;
            r_lpkt[r_wr_ptr] <= w_lpkt;
            r_bpt[r_wr_ptr]  <= w_bpt;
        end
    end

endmodule
